// File: rtl/series_eval_ctrl.sv
// Sequential power-series evaluator: result = sum coef[i]*x^i, i = 0..N_TERMS-1,
// one term per cycle from a combinational coefficient table, saturating fixed point.
module series_eval_ctrl #(
  parameter int N_TERMS = 8,
  parameter int FRAC    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] x,
  output logic        [3:0]  lut_address,
  input  logic signed [15:0] lut_data,
  output logic signed [15:0] result,
  output logic               busy,
  output logic               done,
  output logic               ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic signed [15:0] ONE  = 16'(1 << FRAC);
  localparam logic        [3:0]  LAST = 4'(N_TERMS - 1);

  state_t state, state_nxt;

  logic signed [15:0] x_lat, pow, acc;
  logic        [3:0]  cnt;
  logic               last;

  logic signed [31:0] prod_term, term_full, sum_full, prod_pow, pow_full;
  logic signed [15:0] term, acc_nxt, pow_nxt;
  logic               clamp_any;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic clamps(input logic signed [31:0] v);
    return (v > 32'sd32767) || (v < -32'sd32768);
  endfunction

  // Full-width products; sums done at 32 bits so the clamp sees the true value
  assign prod_term = lut_data * pow;
  assign term_full = prod_term >>> FRAC;
  assign term      = sat16(term_full);
  assign sum_full  = acc + term;
  assign acc_nxt   = sat16(sum_full);
  assign prod_pow  = pow * x_lat;
  assign pow_full  = prod_pow >>> FRAC;
  assign pow_nxt   = sat16(pow_full);
  assign clamp_any = clamps(term_full) | clamps(sum_full) | clamps(pow_full);
  assign last      = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lut_address = 4'd0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      RUN:     begin lut_address = cnt; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_lat  <= '0;
      pow    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_lat <= x;
          pow   <= ONE;
          acc   <= '0;
          cnt   <= '0;
          ovf   <= 1'b0;
        end
        RUN: begin
          acc <= acc_nxt;
          pow <= pow_nxt;
          ovf <= ovf | clamp_any;
          if (last) begin
            result <= acc_nxt;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_series_eval_ctrl.sv
// Directed bench for series_eval_ctrl: all-ones coefficient table, several x values,
// start filtering, mid-run reset and back-to-back operation.
module tb_series_eval_ctrl;
  localparam int N = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [15:0] x;
  logic        [3:0]  lut_address;
  logic signed [15:0] lut_data;
  logic signed [15:0] result;
  logic               busy, done, ovf;

  int checks = 0;
  int fails  = 0;

  series_eval_ctrl #(.N_TERMS(N), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x),
    .lut_address(lut_address), .lut_data(lut_data),
    .result(result), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Coefficient table: every entry is 1.0
  logic [15:0] coef [16];
  initial for (int i = 0; i < 16; i++) coef[i] = 16'h0100;
  assign lut_data = coef[lut_address];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Start pulse, walk the RUN cycles checking addresses, then check the DONE cycle.
  task automatic run_op(input string tag, input logic [15:0] xv,
                        input logic [15:0] exp_res, input logic exp_ovf);
    x = xv;
    start = 1'b1;
    tick();
    start = 1'b0;
    x = 16'h7123; // must not disturb the ongoing operation
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {12'd0, lut_address}, 16'(i));
      chk($sformatf("%s_busy%0d", tag, i), {15'd0, busy}, 16'd1);
      chk($sformatf("%s_nodone%0d", tag, i), {15'd0, done}, 16'd0);
      tick();
    end
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    chk({tag, "_busy_done"}, {15'd0, busy}, 16'd0);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_ovf"}, {15'd0, ovf}, {15'd0, exp_ovf});
    tick();
    chk({tag, "_idle_done"}, {15'd0, done}, 16'd0);
    chk({tag, "_idle_addr"}, {12'd0, lut_address}, 16'd0);
    chk({tag, "_hold_result"}, result, exp_res);
  endtask

  initial begin
    int dcnt, dk, dk2;
    rst = 1'b1;
    start = 1'b1;
    x = 16'h0080;
    tick();
    tick();
    chk("rst_result", result, 16'h0000);
    chk("rst_ovf", {15'd0, ovf}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_addr", {12'd0, lut_address}, 16'd0);
    start = 1'b0;
    rst = 1'b0;
    tick();

    run_op("half", 16'h0080, 16'h01FE, 1'b0);
    run_op("zero", 16'h0000, 16'h0100, 1'b0);
    run_op("neg1", 16'hFF00, 16'h0000, 1'b0);
    run_op("two",  16'h0200, 16'h7FFF, 1'b1);
    run_op("half2", 16'h0080, 16'h01FE, 1'b0);

    // start re-asserted during RUN cycle 3 is ignored
    x = 16'h0080;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    dcnt = 0; dk = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        dcnt++;
        dk = k;
        chk("ign_result", result, 16'h01FE);
      end
    end
    chk("ign_done_count", 16'(dcnt), 16'd1);
    chk("ign_done_time", 16'(dk), 16'd5);

    // reset during RUN cycle 4 aborts with no done pulse
    x = 16'h0200;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy_pre", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_result", result, 16'h0000);
    chk("abort_ovf", {15'd0, ovf}, 16'd0);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_done", {15'd0, done}, 16'd0);
    chk("abort_addr", {12'd0, lut_address}, 16'd0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) dcnt++;
    end
    chk("abort_quiet", 16'(dcnt), 16'd0);

    // start held high: one operation every 10 cycles
    x = 16'h0080;
    start = 1'b1;
    dcnt = 0; dk = 0; dk2 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        dcnt++;
        if (dcnt == 1) dk = k; else dk2 = k;
        chk($sformatf("held_result%0d", dcnt), result, 16'h01FE);
      end
    end
    start = 1'b0;
    chk("held_count", 16'(dcnt), 16'd2);
    chk("held_first", 16'(dk), 16'd9);
    chk("held_period", 16'(dk2 - dk), 16'd10);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) dcnt++;
    end
    chk("held_quiet", 16'(dcnt), 16'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
